agc_a2_timer: RTL and testbench
===============================

# agc_a2_timer

Timing generator of the AGC core (module A2). Sampled by the fast FPGA clock `SIM_CLK`, it converts the 2.048 MHz crystal square wave `CLOCK` into everything downstream logic runs on:
- the four-phase time-pulse clocks and the read/write/clear strobes;
- the 12-pulse memory-cycle ring;
- the P01–P05 / FS01 scaler and its F01 strobes.

## Interface
Parameters: none.

Ports in bullet order (name, direction, width, meaning):
- `SIM_CLK` in 1: sole clock, 50 MHz; every flop is rising-edge on it.
- `RESET` in 1: asynchronous active-high reset.
- `CLOCK` in 1: 2.048 MHz square wave, asynchronous data input; each half period spans at least 4 `SIM_CLK` cycles.
- `STOP` in 1: high freezes the phase, ring and scaler state.
- Phase/strobe outputs, 1 bit each: `CLK`, `PHS2`, `PHS2_`, `PHS4`, `PHS4_`, `CT`, `CT_`, `RT`, `WT`, `WT_`, `TT_`, `OVFSTB_`, `MONWT`, `Q2A`.
- Ring outputs, 1 bit each: `RINGA_`, `RINGB_`, `ODDSET_`, `EVNSET`, `EVNSET_`.
- Scaler outputs, 1 bit each: `P01`–`P05` and `P01_`–`P05_`.
- F01 outputs, 1 bit each: `F01A`, `F01B`, `F01C`, `F01D`, `FS01`, `FS01_`.
- Misc outputs, 1 bit each: `SB0`, `SB1`, `SB2`, `SB4`, `EDSET`.

Declaration (positional) order: `CLOCK`, `STOP`, then the outputs in the order listed above, then `SIM_CLK`, then `RESET`. A trailing `_` means the exact complement of the same-named signal.

## Operation
Input sampling:
- `CLOCK` and `STOP` each pass through a 2-FF synchronizer.
- `CLK` is the synchronized `CLOCK`.
- An "edge" is any change of synchronized `CLOCK`, rising or falling, which gives a 4.096 MHz event rate.

Phase counter (`ph`, 2 bits):
- Advances 0→1→2→3→0 on each edge while synchronized `STOP` = 0.
- Four phases form one time pulse of 976.6 ns.

Phase decode (all outputs registered):
- `CT` = (ph==0)
- `PHS2` = `RT` = (ph==1)
- `WT` = `MONWT` = (ph==2)
- `PHS4` = (ph==3); `TT_` = `OVFSTB_` = ~(ph==3)
- `Q2A` = (ph>=2)
- `SB0` = ph∈{0,1}, `SB1` = ph∈{1,2}, `SB2` = ph∈{2,3}, `SB4` = ph∈{3,0}

Ring counter (`t`, 0..11, T01..T12):
- Increments on the edge taking ph 3→0, wrapping 11→0.
- One 12-pulse cycle is the 11.72 µs memory cycle time (MCT).
- `EVNSET` = t odd (even-numbered pulse T02, T04, …); `ODDSET_` = ~(t even).
- `RINGA_` is low during ph==3 of odd pulses; `RINGB_` is low during ph==3 of even pulses.
- `EDSET` is high during ph==3 of T12 (t==11).

Scaler (`p`, 5 bits):
- Increments at every time-pulse boundary, together with `t`.
- `P0n` = p[n-1], so `P01` is a 512 kHz square wave and `P05` is 32 kHz.
- `FS01` toggles when p wraps 31→0, giving a 16 kHz square wave.
- F01 strobes are one time pulse wide:
  - `F01A`: first pulse after `FS01` rises (p==0, `FS01`=1).
  - `F01B`: first pulse after `FS01` falls (p==0, `FS01`=0).
  - `F01C`: p==16 with `FS01`=1.
  - `F01D`: p==16 with `FS01`=0.

`STOP`:
- Holds ph, t, p and `FS01`; all decoded outputs hold their current levels.
- `CLK` keeps following `CLOCK`.
- On release, counting resumes from the held state at the next edge.

## Timing
- Reset (async assert, sync deassert): synchronizers 0, ph=0, t=0, p=0, `FS01`=0.
- Output values during reset:
  - High: `CT`, `SB0`, `SB4`, `PHS2_`, `PHS4_`, `WT_`, `TT_`, `OVFSTB_`, `RINGA_`, `RINGB_`, `EVNSET_`, every `P0n_`, `FS01_`.
  - Low: `CLK`, `PHS2`, `PHS4`, `RT`, `WT`, `MONWT`, `Q2A`, `SB1`, `SB2`, `CT_`, `EVNSET`, `ODDSET_`, `EDSET`, `P01`–`P05`, `FS01`.
  - `F01B` = 1 (p==0, `FS01`=0); `F01A`, `F01C`, `F01D` = 0.
- Latency: 3 `SIM_CLK` cycles from a `CLOCK` edge to updated outputs (2 synchronizer + 1 output register).
- Edges arriving while `RESET` is high are ignored. The first edge after release moves ph to 1.
- `STOP` takes effect 2 cycles after its change. An edge coinciding with synchronized `STOP` rising is not counted.
- Wrap events (t 11→0, p 31→0, `FS01` toggle) all land on the same `SIM_CLK` cycle as ph 3→0.

## Test plan
- Reset then free-run `CLOCK` (period 488.28 ns): `PHS2` pulses every 976.6 ns, 244 ns wide; `CT`/`RT`/`WT`/`PHS4` are mutually exclusive and cycle in that order.
- Run 30 µs: `EDSET` pulses every 11.72 µs; `EVNSET` alternates per pulse; `RINGA_` and `RINGB_` alternate and are never low together.
- Count time pulses: `P01` toggles every pulse; `P05` rises after 16 pulses (15.6 µs); `FS01` rises after 32 pulses, coinciding with one `F01A` pulse.
- Assert `STOP` for 5 µs mid-pulse: ph/t/p are frozen and `CLK` still toggles; after release, sequence counts continue with no skipped phase.
- Assert `RESET` asynchronously mid-MCT: outputs return to the reset values above within the same cycle; after release, the first edge gives ph=1 (`PHS2` high).
- Compare every `_` output against its true-polarity pair each cycle: always complementary.

Source files
------------

// File: rtl/agc_a2_timer.sv
`default_nettype none
// ============================================================================
// agc_a2_timer : AGC A2 timing generator (phases, strobes, MCT ring, scaler)
// Rev 1.0
// ============================================================================
module agc_a2_timer (
  input  logic CLOCK,
  input  logic STOP,
  output logic CLK,
  output logic PHS2,
  output logic PHS2_,
  output logic PHS4,
  output logic PHS4_,
  output logic CT,
  output logic CT_,
  output logic RT,
  output logic WT,
  output logic WT_,
  output logic TT_,
  output logic OVFSTB_,
  output logic MONWT,
  output logic Q2A,
  output logic RINGA_,
  output logic RINGB_,
  output logic ODDSET_,
  output logic EVNSET,
  output logic EVNSET_,
  output logic P01,
  output logic P02,
  output logic P03,
  output logic P04,
  output logic P05,
  output logic P01_,
  output logic P02_,
  output logic P03_,
  output logic P04_,
  output logic P05_,
  output logic F01A,
  output logic F01B,
  output logic F01C,
  output logic F01D,
  output logic FS01,
  output logic FS01_,
  output logic SB0,
  output logic SB1,
  output logic SB2,
  output logic SB4,
  output logic EDSET,
  input  logic SIM_CLK,
  input  logic RESET
);

  localparam logic [3:0] C_T_LAST = 4'd11;
  localparam logic [4:0] C_P_LAST = 5'd31;

  logic       r_rst_meta, r_rst_sync;
  logic       r_clk_s1, r_clk_s2, r_clk_s3;
  logic       r_stop_s1, r_stop_s2;
  logic [1:0] r_ph;
  logic [3:0] r_t;
  logic [4:0] r_p;
  logic       r_fs;
  logic       r_ct, r_phs2, r_wt, r_phs4, r_q2a;
  logic       r_sb0, r_sb1, r_sb4;
  logic       r_evnset, r_ringa_n, r_ringb_n, r_edset;
  logic       r_f01a, r_f01b, r_f01c, r_f01d;

  logic       w_adv, w_tp, w_ph3_nx;
  logic [1:0] w_ph_nx;
  logic [3:0] w_t_nx;
  logic [4:0] w_p_nx;
  logic       w_fs_nx;

  // Reset asserts immediately, releases two SIM_CLK edges later.
  always_ff @(posedge SIM_CLK or posedge RESET) begin
    if (RESET) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  // A counted edge is a change of synchronized CLOCK with synchronized STOP low.
  assign w_adv    = (r_clk_s2 ^ r_clk_s3) & ~r_stop_s2;
  assign w_tp     = w_adv & (r_ph == 2'd3);
  assign w_ph_nx  = w_adv ? r_ph + 2'd1 : r_ph;
  assign w_t_nx   = w_tp ? ((r_t == C_T_LAST) ? 4'd0 : r_t + 4'd1) : r_t;
  assign w_p_nx   = w_tp ? r_p + 5'd1 : r_p;
  assign w_fs_nx  = (w_tp && (r_p == C_P_LAST)) ? ~r_fs : r_fs;
  assign w_ph3_nx = (w_ph_nx == 2'd3);

  always_ff @(posedge SIM_CLK or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_clk_s1  <= 1'b0;
      r_clk_s2  <= 1'b0;
      r_clk_s3  <= 1'b0;
      r_stop_s1 <= 1'b0;
      r_stop_s2 <= 1'b0;
      r_ph      <= 2'd0;
      r_t       <= 4'd0;
      r_p       <= 5'd0;
      r_fs      <= 1'b0;
      r_ct      <= 1'b1;
      r_phs2    <= 1'b0;
      r_wt      <= 1'b0;
      r_phs4    <= 1'b0;
      r_q2a     <= 1'b0;
      r_sb0     <= 1'b1;
      r_sb1     <= 1'b0;
      r_sb4     <= 1'b1;
      r_evnset  <= 1'b0;
      r_ringa_n <= 1'b1;
      r_ringb_n <= 1'b1;
      r_edset   <= 1'b0;
      r_f01a    <= 1'b0;
      r_f01b    <= 1'b1;
      r_f01c    <= 1'b0;
      r_f01d    <= 1'b0;
    end else begin
      r_clk_s1  <= CLOCK;
      r_clk_s2  <= r_clk_s1;
      r_clk_s3  <= r_clk_s2;
      r_stop_s1 <= STOP;
      r_stop_s2 <= r_stop_s1;
      r_ph      <= w_ph_nx;
      r_t       <= w_t_nx;
      r_p       <= w_p_nx;
      r_fs      <= w_fs_nx;
      // Decodes are taken from next state so they land with the counters.
      r_ct      <= (w_ph_nx == 2'd0);
      r_phs2    <= (w_ph_nx == 2'd1);
      r_wt      <= (w_ph_nx == 2'd2);
      r_phs4    <= w_ph3_nx;
      r_q2a     <= w_ph_nx[1];
      r_sb0     <= ~w_ph_nx[1];
      r_sb1     <= w_ph_nx[1] ^ w_ph_nx[0];
      r_sb4     <= ~(w_ph_nx[1] ^ w_ph_nx[0]);
      r_evnset  <= w_t_nx[0];
      r_ringa_n <= ~(w_ph3_nx & ~w_t_nx[0]);
      r_ringb_n <= ~(w_ph3_nx & w_t_nx[0]);
      r_edset   <= w_ph3_nx & (w_t_nx == C_T_LAST);
      r_f01a    <= (w_p_nx == 5'd0) & w_fs_nx;
      r_f01b    <= (w_p_nx == 5'd0) & ~w_fs_nx;
      r_f01c    <= (w_p_nx == 5'd16) & w_fs_nx;
      r_f01d    <= (w_p_nx == 5'd16) & ~w_fs_nx;
    end
  end

  assign CLK     = r_clk_s2;
  assign CT      = r_ct;
  assign CT_     = ~r_ct;
  assign PHS2    = r_phs2;
  assign PHS2_   = ~r_phs2;
  assign RT      = r_phs2;
  assign WT      = r_wt;
  assign WT_     = ~r_wt;
  assign MONWT   = r_wt;
  assign PHS4    = r_phs4;
  assign PHS4_   = ~r_phs4;
  assign TT_     = ~r_phs4;
  assign OVFSTB_ = ~r_phs4;
  assign Q2A     = r_q2a;
  assign SB0     = r_sb0;
  assign SB1     = r_sb1;
  assign SB2     = r_q2a;
  assign SB4     = r_sb4;
  assign EVNSET  = r_evnset;
  assign EVNSET_ = ~r_evnset;
  assign ODDSET_ = r_evnset;
  assign RINGA_  = r_ringa_n;
  assign RINGB_  = r_ringb_n;
  assign EDSET   = r_edset;
  assign {P05, P04, P03, P02, P01}      = r_p;
  assign {P05_, P04_, P03_, P02_, P01_} = ~r_p;
  assign FS01    = r_fs;
  assign FS01_   = ~r_fs;
  assign F01A    = r_f01a;
  assign F01B    = r_f01b;
  assign F01C    = r_f01c;
  assign F01D    = r_f01d;

endmodule
`default_nettype wire

// File: tb/tb_agc_a2_timer.sv
`default_nettype none
// ============================================================================
// tb_agc_a2_timer : directed vector bench for agc_a2_timer
// Rev 1.0
// ============================================================================
module tb_agc_a2_timer;

  localparam int C_HALF = 6;

  logic SIM_CLK, RESET, CLOCK, STOP;
  logic CLK, PHS2, PHS2_, PHS4, PHS4_, CT, CT_, RT, WT, WT_, TT_, OVFSTB_, MONWT, Q2A;
  logic RINGA_, RINGB_, ODDSET_, EVNSET, EVNSET_;
  logic P01, P02, P03, P04, P05, P01_, P02_, P03_, P04_, P05_;
  logic F01A, F01B, F01C, F01D, FS01, FS01_;
  logic SB0, SB1, SB2, SB4, EDSET;

  int checks = 0;
  int failures = 0;

  agc_a2_timer dut (
    .CLOCK(CLOCK), .STOP(STOP),
    .CLK(CLK), .PHS2(PHS2), .PHS2_(PHS2_), .PHS4(PHS4), .PHS4_(PHS4_),
    .CT(CT), .CT_(CT_), .RT(RT), .WT(WT), .WT_(WT_), .TT_(TT_),
    .OVFSTB_(OVFSTB_), .MONWT(MONWT), .Q2A(Q2A),
    .RINGA_(RINGA_), .RINGB_(RINGB_), .ODDSET_(ODDSET_), .EVNSET(EVNSET), .EVNSET_(EVNSET_),
    .P01(P01), .P02(P02), .P03(P03), .P04(P04), .P05(P05),
    .P01_(P01_), .P02_(P02_), .P03_(P03_), .P04_(P04_), .P05_(P05_),
    .F01A(F01A), .F01B(F01B), .F01C(F01C), .F01D(F01D), .FS01(FS01), .FS01_(FS01_),
    .SB0(SB0), .SB1(SB1), .SB2(SB2), .SB4(SB4), .EDSET(EDSET),
    .SIM_CLK(SIM_CLK), .RESET(RESET)
  );

  initial SIM_CLK = 1'b0;
  always #10 SIM_CLK = ~SIM_CLK;

  typedef struct {
    int unsigned edges;   // CLOCK edges applied before checking
    logic [3:0]  onehot;  // {CT, PHS2, WT, PHS4}
    logic [3:0]  sb;      // {SB0, SB1, SB2, SB4}
    logic        q2a;
    logic [3:0]  ring;    // {EVNSET, RINGA_, RINGB_, EDSET}
    logic [4:0]  p;
    logic        fs;
    logic [3:0]  f01;     // {F01A, F01B, F01C, F01D}
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply_edges(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge SIM_CLK);
      CLOCK = ~CLOCK;
      repeat (C_HALF - 1) @(negedge SIM_CLK);
    end
  endtask

  task automatic check_vec(input int i, input vec_t v);
    logic ct, phs2, wt, phs4, evn;
    ct = v.onehot[3]; phs2 = v.onehot[2]; wt = v.onehot[1]; phs4 = v.onehot[0];
    evn = v.ring[3];
    chk("phase",  i, {28'd0, CT, PHS2, WT, PHS4}, {28'd0, v.onehot});
    chk("sb",     i, {28'd0, SB0, SB1, SB2, SB4}, {28'd0, v.sb});
    chk("q2a",    i, {31'd0, Q2A}, {31'd0, v.q2a});
    chk("ring",   i, {28'd0, EVNSET, RINGA_, RINGB_, EDSET}, {28'd0, v.ring});
    chk("scaler", i, {27'd0, P05, P04, P03, P02, P01}, {27'd0, v.p});
    chk("fs01",   i, {31'd0, FS01}, {31'd0, v.fs});
    chk("f01",    i, {28'd0, F01A, F01B, F01C, F01D}, {28'd0, v.f01});
    chk("pairs",  i,
        {16'd0, PHS2_, PHS4_, CT_, WT_, TT_, OVFSTB_, EVNSET_, ODDSET_, RT, MONWT, FS01_,
         P05_, P04_, P03_, P02_, P01_},
        {16'd0, ~phs2, ~phs4, ~ct, ~wt, ~phs4, ~phs4, ~evn, evn, phs2, wt, ~v.fs, ~v.p});
    chk("clk",    i, {31'd0, CLK}, {31'd0, CLOCK});
  endtask

  initial begin
    // Cumulative edge count E: ph=E%4, t=(E/4)%12, p=(E/4)%32, FS01=(E/128)%2.
    vecs[0]  = '{0,  4'b1000, 4'b1001, 1'b0, 4'b0110, 5'd0,  1'b0, 4'b0100}; // E=0
    vecs[1]  = '{1,  4'b0100, 4'b1100, 1'b0, 4'b0110, 5'd0,  1'b0, 4'b0100}; // E=1
    vecs[2]  = '{1,  4'b0010, 4'b0110, 1'b1, 4'b0110, 5'd0,  1'b0, 4'b0100}; // E=2
    vecs[3]  = '{1,  4'b0001, 4'b0011, 1'b1, 4'b0010, 5'd0,  1'b0, 4'b0100}; // E=3
    vecs[4]  = '{1,  4'b1000, 4'b1001, 1'b0, 4'b1110, 5'd1,  1'b0, 4'b0000}; // E=4
    vecs[5]  = '{3,  4'b0001, 4'b0011, 1'b1, 4'b1100, 5'd1,  1'b0, 4'b0000}; // E=7
    vecs[6]  = '{40, 4'b0001, 4'b0011, 1'b1, 4'b1101, 5'd11, 1'b0, 4'b0000}; // E=47 T12
    vecs[7]  = '{1,  4'b1000, 4'b1001, 1'b0, 4'b0110, 5'd12, 1'b0, 4'b0000}; // E=48 wrap
    vecs[8]  = '{16, 4'b1000, 4'b1001, 1'b0, 4'b0110, 5'd16, 1'b0, 4'b0001}; // E=64
    vecs[9]  = '{63, 4'b0001, 4'b0011, 1'b1, 4'b1100, 5'd31, 1'b0, 4'b0000}; // E=127
    vecs[10] = '{1,  4'b1000, 4'b1001, 1'b0, 4'b0110, 5'd0,  1'b1, 4'b1000}; // E=128
    vecs[11] = '{64, 4'b1000, 4'b1001, 1'b0, 4'b0110, 5'd16, 1'b1, 4'b0010}; // E=192
    vecs[12] = '{64, 4'b1000, 4'b1001, 1'b0, 4'b0110, 5'd0,  1'b0, 4'b0100}; // E=256

    RESET = 1'b1;
    CLOCK = 1'b0;
    STOP  = 1'b0;
    repeat (5) @(negedge SIM_CLK);
    RESET = 1'b0;
    repeat (6) @(negedge SIM_CLK);

    for (int i = 0; i < 13; i++) begin
      apply_edges(vecs[i].edges);
      check_vec(i, vecs[i]);
    end

    // STOP freezes state at ph=0 while CLK keeps following CLOCK.
    @(negedge SIM_CLK);
    STOP = 1'b1;
    repeat (4) @(negedge SIM_CLK);
    for (int i = 0; i < 5; i++) begin
      apply_edges(1);
      chk("stop_hold_ct", i, {31'd0, CT}, 32'd1);
      chk("stop_clk", i, {31'd0, CLK}, {31'd0, CLOCK});
    end
    chk("stop_hold_p", 0, {26'd0, FS01, P05, P04, P03, P02, P01}, 32'd0);
    STOP = 1'b0;
    repeat (4) @(negedge SIM_CLK);
    apply_edges(1);
    chk("resume_phs2", 0, {31'd0, PHS2}, 32'd1);
    chk("resume_ct", 0, {31'd0, CT}, 32'd0);

    // Edge arriving together with STOP is not counted.
    @(negedge SIM_CLK);
    CLOCK = ~CLOCK;
    STOP  = 1'b1;
    repeat (5) @(negedge SIM_CLK);
    chk("coincide_phs2", 0, {31'd0, PHS2}, 32'd1);
    STOP = 1'b0;
    repeat (4) @(negedge SIM_CLK);
    apply_edges(1);
    chk("after_coincide_wt", 0, {31'd0, WT}, 32'd1);

    // E=263: ph=3, t=5, p=1; then async reset between clock edges.
    apply_edges(5);
    chk("pre_reset", 0, {28'd0, PHS4, EVNSET, P01, F01B}, 32'b1110);
    @(negedge SIM_CLK);
    #3 RESET = 1'b1;
    #1;
    chk("async_reset", 0, {26'd0, CT, PHS4, EVNSET, P01, F01B, RINGB_}, 32'b100011);
    apply_edges(3);
    chk("reset_ignores_edges", 0, {29'd0, CT, PHS2, CLK}, 32'b100);
    @(negedge SIM_CLK);
    CLOCK = 1'b0;
    repeat (4) @(negedge SIM_CLK);
    RESET = 1'b0;
    repeat (6) @(negedge SIM_CLK);
    chk("post_reset_ct", 0, {30'd0, CT, PHS2}, 32'b10);
    apply_edges(1);
    chk("first_edge_phs2", 0, {30'd0, CT, PHS2}, 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
